// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to let divide-by-zero, signed overflow and zero-operand multiplies skip CALC.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            MDctrl,
    input  logic [DATA_WIDTH-1:0] MDop1,
    input  logic [DATA_WIDTH-1:0] MDop2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] MDout
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             launch_c, finish_c, step_c, early_c;
    logic [2:0]       op_q;
    logic             neg_a_q, neg_b_q, div0_q, ovf_q, mzero_q;
    logic [W-1:0]     a_q, b_q;
    logic [2*W-1:0]   p_q, p_next_c;
    logic [CNT_W-1:0] cnt_q;

    // Launch-time operand decode
    logic         is_div_c, signed_a_c, signed_b_c, neg_a_c, neg_b_c;
    logic         div0_c, ovf_c, mzero_c;
    logic [W-1:0] mag_a_c, mag_b_c;

    assign is_div_c   = MDctrl[2];
    assign signed_a_c = (MDctrl[2] & ~MDctrl[0]) | (~MDctrl[2] & (MDctrl[1] ^ MDctrl[0]));
    assign signed_b_c = (MDctrl[2] & ~MDctrl[0]) | (MDctrl == 3'b001);
    assign neg_a_c    = signed_a_c & MDop1[W-1];
    assign neg_b_c    = signed_b_c & MDop2[W-1];
    assign mag_a_c    = neg_a_c ? W'(-MDop1) : MDop1;
    assign mag_b_c    = neg_b_c ? W'(-MDop2) : MDop2;
    assign div0_c     = is_div_c & (MDop2 == '0);
    assign ovf_c      = MDctrl[2] & ~MDctrl[0] & (MDop1 == {1'b1, {(W-1){1'b0}}}) & (&MDop2);
    assign mzero_c    = ~is_div_c & ((MDop1 == '0) | (MDop2 == '0));

`ifdef MULDIV_EARLY_OUT_EN
    assign early_c = div0_c | ovf_c | mzero_c;
`else
    assign early_c = 1'b0;
`endif

    // Next-state and control strobes
    always_comb begin
        state_d  = state_q;
        launch_c = 1'b0;
        finish_c = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    launch_c = 1'b1;
                    state_d  = CALC;
                end
                CALC: if (cnt_q == '0) begin
                    finish_c = 1'b1;
                    state_d  = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign step_c = (state_q == CALC) && (cnt_q != '0) && !flush;

    // One iteration: p_q holds {acc, multiplier} or {remainder, dividend/quotient}
    logic [W:0]   mul_sum_c, div_shift_c;
    logic         div_ge_c;
    logic [W-1:0] div_sub_c;

    always_comb begin
        mul_sum_c   = {1'b0, p_q[2*W-1:W]} + {1'b0, b_q & {W{p_q[0]}}};
        div_shift_c = {p_q[2*W-1:W], p_q[W-1]};
        div_ge_c    = div_shift_c >= {1'b0, b_q};
        div_sub_c   = div_shift_c[W-1:0] - b_q;
        if (op_q[2]) begin
            p_next_c = div_ge_c ? {div_sub_c, p_q[W-2:0], 1'b1}
                                : {div_shift_c[W-1:0], p_q[W-2:0], 1'b0};
        end else begin
            p_next_c = {mul_sum_c, p_q[W-1:1]};
        end
    end

    // Sign fix-up, result select and architected special cases
    logic [2*W-1:0] prod_c;
    logic [W-1:0]   quo_c, rem_c, result_c;

    always_comb begin
        prod_c = (neg_a_q ^ neg_b_q) ? (2*W)'(-p_q) : p_q;
        quo_c  = (neg_a_q ^ neg_b_q) ? W'(-p_q[W-1:0]) : p_q[W-1:0];
        rem_c  = neg_a_q ? W'(-p_q[2*W-1:W]) : p_q[2*W-1:W];
        case (op_q)
            3'b000:                 result_c = prod_c[W-1:0];
            3'b001, 3'b010, 3'b011: result_c = prod_c[2*W-1:W];
            3'b100, 3'b101:         result_c = quo_c;
            default:                result_c = rem_c;
        endcase
        if (div0_q)       result_c = op_q[1] ? a_q : '1;
        else if (ovf_q)   result_c = op_q[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        else if (mzero_q) result_c = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            MDout   <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            mzero_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            busy <= (state_d != IDLE);
            done <= finish_c;
            if (finish_c) MDout <= result_c;
            if (launch_c) begin
                op_q    <= MDctrl;
                neg_a_q <= neg_a_c;
                neg_b_q <= neg_b_c;
                div0_q  <= div0_c;
                ovf_q   <= ovf_c;
                mzero_q <= mzero_c;
                a_q     <= MDop1;
                b_q     <= is_div_c ? mag_b_c : mag_a_c;
                p_q     <= {{W{1'b0}}, (is_div_c ? mag_a_c : mag_b_c)};
                cnt_q   <= early_c ? '0 : CNT_W'(W);
            end else if (step_c) begin
                p_q   <= p_next_c;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, busy/done timing, flush and async reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  MDctrl;
    logic [31:0] MDop1, MDop2;
    logic        busy, done;
    logic [31:0] MDout;

    int total  = 0;
    int passed = 0;
    logic [31:0] last;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO = 1;
`else
    localparam int EO = 33;
`endif

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .MDctrl(MDctrl), .MDop1(MDop1), .MDop2(MDop2),
        .busy(busy), .done(done), .MDout(MDout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op, optionally poke start while busy, and check latency, result and busy/done shape
    task automatic run(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat, input bit poke);
        int n;
        bit busy_ok;
        @(negedge clk);
        MDctrl = ctrl; MDop1 = a; MDop2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; MDctrl = 3'b000; MDop1 = 32'h0; MDop2 = 32'h0;
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && n == 5) begin
                start = 1'b1; MDctrl = 3'b101; MDop1 = 32'h1111; MDop2 = 32'h3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, 64'(MDout), 64'(exp));
        check({tag, " busy held"}, 64'({busy_ok, busy}), 64'(2'b11));
        @(posedge clk);
        #1;
        check({tag, " done/busy drop"}, 64'({done, busy}), 64'(2'b00));
        check({tag, " result held"}, 64'(MDout), 64'(exp));
        last = exp;
    endtask

    initial begin
        bit saw_done;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        MDctrl = 3'b000; MDop1 = 32'h0; MDop2 = 32'h0;
        last = 32'h0;
        #12;
        check("reset outputs", 64'({busy, done, MDout}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("MUL 7*-3",          3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
        run("MULH min*min",      3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
        run("MULHU min*min",     3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
        run("MULHSU -1*max",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
        run("DIV -7/2",          3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33, 1'b0);
        run("REM -7/2",          3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33, 1'b0);
        run("DIVU 100/7",        3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0);
        run("REMU 100/7",        3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0);
        run("DIVU 5/0",          3'b101, 32'd5,        32'h0,        32'hFFFFFFFF, EO, 1'b0);
        run("REM 5/0",           3'b110, 32'd5,        32'h0,        32'd5,        EO, 1'b0);
        run("DIV -5/0",          3'b100, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFF, EO, 1'b0);
        run("DIV ovf",           3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EO, 1'b0);
        run("REM ovf",           3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        EO, 1'b0);
        run("MUL 0*5",           3'b000, 32'h0,        32'd5,        32'h0,        EO, 1'b0);
        run("MULH x*0",          3'b001, 32'h12345678, 32'h0,        32'h0,        EO, 1'b0);
        run("DIVU 0x64/0x64",    3'b101, 32'd100,      32'd100,      32'd1,        33, 1'b0);

        // Flush in CALC cycle 10
        @(negedge clk);
        MDctrl = 3'b100; MDop1 = 32'd1000; MDop2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy/done", 64'({busy, done}), 64'(2'b00));
        check("flush MDout kept", 64'(MDout), 64'(last));
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("flush no done", 64'(saw_done), 64'(0));

        // Flush and start together in IDLE: nothing launches
        @(negedge clk);
        MDctrl = 3'b000; MDop1 = 32'd9; MDop2 = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush beats start", 64'({busy, done}), 64'(2'b00));
        repeat (3) @(posedge clk);
        #1;
        check("flush beats start later", 64'({busy, done, MDout}), 64'({2'b00, last}));

        run("MUL 3*4 poke", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        MDctrl = 3'b000; MDop1 = 32'd3; MDop2 = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 64'({busy, done, MDout}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("MUL -1*-1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
